// File: rtl/inst_fetch_seq_pkg.sv
// Shared types and constants for the boot-flash instruction fetch sequencer.
package fetch_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DWELL,
        ST_DONE
    } fetch_state_e;

    localparam logic [1:0]  INST_SIZE_WORD = 2'b10;
    localparam logic [31:0] ADDR_STEP      = 32'd4;

    function automatic logic [31:0] next_addr(input logic [31:0] addr);
        return addr + ADDR_STEP;
    endfunction

endpackage

// File: rtl/inst_fetch_seq_sat_counter.sv
// Saturating up-counter; hit marks the enabled cycle that completes the MAX-th count.
module sat_counter #(
    parameter int unsigned MAX = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic hit
);

    localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // MAX of zero behaves as a single-cycle count
    assign hit = (MAX == 0) || (({1'b0, cnt_q} + 1'b1) >= {1'b0, MAX_V});

endmodule

// File: rtl/inst_fetch_seq.sv
// Sram-like instruction-port master that walks boot-flash words into the display.
// Build option FETCH_LOOP_EN: wrap to BASE_ADDR after the last word and pulse done per pass.
module inst_fetch_seq
    import fetch_seq_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h1fc00000,
    parameter int unsigned WORD_COUNT     = 16,
    parameter int unsigned DWELL_CYCLES   = 50000000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    localparam int IDX_W = $clog2(WORD_COUNT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic             inst_req,
    output logic             inst_wr,
    output logic [1:0]       inst_size,
    output logic [31:0]      inst_addr,
    input  logic             inst_addr_ok,
    input  logic             inst_data_ok,
    input  logic [31:0]      inst_rdata,
    output logic [31:0]      disp_data,
    output logic             disp_valid,
    output logic [IDX_W-1:0] word_idx,
    output logic             done,
    output logic             err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_COUNT - 1);

    fetch_state_e     state_q, state_d;
    logic             req_q, req_d;
    logic [31:0]      addr_q, addr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] word_idx_q, word_idx_d;
    logic [31:0]      disp_data_q, disp_data_d;
    logic             disp_valid_q, disp_valid_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             capture;
    logic             dwell_hit;
    logic             tmo_hit;

    sat_counter #(.MAX(DWELL_CYCLES)) u_dwell_cnt (
        .clk    (clk),
        .rst    (rst),
        .load   (state_q != ST_DWELL),
        .enable (state_q == ST_DWELL),
        .hit    (dwell_hit)
    );

    sat_counter #(.MAX(TIMEOUT_CYCLES)) u_timeout_cnt (
        .clk    (clk),
        .rst    (rst),
        .load   (state_q != ST_WAIT),
        .enable (state_q == ST_WAIT),
        .hit    (tmo_hit)
    );

    // Data may arrive with the address acceptance, skipping WAIT entirely
    assign capture = ((state_q == ST_REQ) && inst_addr_ok && inst_data_ok) ||
                     ((state_q == ST_WAIT) && inst_data_ok);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        idx_d        = idx_q;
        word_idx_d   = word_idx_q;
        disp_data_d  = disp_data_q;
        disp_valid_d = 1'b0;
        err_d        = err_q;
`ifdef FETCH_LOOP_EN
        done_d       = 1'b0;
`else
        done_d       = done_q;
`endif
        if (capture) begin
            disp_data_d  = inst_rdata;
            disp_valid_d = 1'b1;
            word_idx_d   = idx_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (inst_addr_ok) state_d = inst_data_ok ? ST_DWELL : ST_WAIT;
            end
            ST_WAIT: begin
                if (inst_data_ok) begin
                    state_d = ST_DWELL;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DWELL: begin
                if (dwell_hit) begin
                    if (idx_q == LAST_IDX) begin
                        done_d = 1'b1;
`ifdef FETCH_LOOP_EN
                        idx_d   = '0;
                        addr_d  = BASE_ADDR;
                        state_d = run ? ST_REQ : ST_IDLE;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        addr_d  = next_addr(addr_q);
                        state_d = run ? ST_REQ : ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        req_d = (state_d == ST_REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            req_q        <= 1'b0;
            addr_q       <= BASE_ADDR;
            idx_q        <= '0;
            word_idx_q   <= '0;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            idx_q        <= idx_d;
            word_idx_q   <= word_idx_d;
            disp_data_q  <= disp_data_d;
            disp_valid_q <= disp_valid_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign inst_req   = req_q;
    assign inst_wr    = 1'b0;
    assign inst_size  = INST_SIZE_WORD;
    assign inst_addr  = addr_q;
    assign disp_data  = disp_data_q;
    assign disp_valid = disp_valid_q;
    assign word_idx   = word_idx_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_inst_fetch_seq.sv
// Directed bench for inst_fetch_seq with a small sram-like slave stub.
`timescale 1ns/1ps
module tb_inst_fetch_seq;

    localparam logic [31:0] BASE  = 32'h1fc00000;
    localparam logic [31:0] XOR_K = 32'hA5A5A5A5;
    localparam int WC = 4;
    localparam int DW = 3;
    localparam int TO = 20;
    localparam int M_NORMAL = 0;
    localparam int M_SAME   = 1;
    localparam int M_NODATA = 2;
    localparam int M_OFF    = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic [31:0] disp_data;
    logic        disp_valid;
    logic [2:0]  word_idx;
    logic        done, err;

    logic        stub_addr_ok = 1'b0;
    logic        stub_data_ok = 1'b0;
    logic [31:0] stub_rdata = '0;
    logic        frc_data_ok;
    logic [31:0] frc_rdata;
    int          mode;

    assign inst_addr_ok = stub_addr_ok;
    assign inst_data_ok = stub_data_ok | frc_data_ok;
    assign inst_rdata   = frc_data_ok ? frc_rdata : stub_rdata;

    inst_fetch_seq #(
        .BASE_ADDR      (BASE),
        .WORD_COUNT     (WC),
        .DWELL_CYCLES   (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .disp_data    (disp_data),
        .disp_valid   (disp_valid),
        .word_idx     (word_idx),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] addr_log[$];
    int          ack_cyc_log[$];
    logic [31:0] cap_data_log[$];
    int          cap_idx_log[$];
    int          cap_cyc_log[$];
    int          rise_cyc_log[$];
    int          done_hi = 0;
    int          done_rises = 0;
    logic        prev_req = 1'b0;
    logic        prev_done = 1'b0;

    // Slave stub: addr_ok one cycle after req, data_ok two cycles after addr_ok
    bit          req_seen = 1'b0;
    int          pend = 0;
    logic [31:0] paddr = '0;
    always @(negedge clk) begin
        stub_addr_ok = 1'b0;
        stub_data_ok = 1'b0;
        if (rst) begin
            pend     = 0;
            req_seen = 1'b0;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                stub_data_ok = 1'b1;
                stub_rdata   = paddr ^ XOR_K;
            end
        end else if (inst_req && mode != M_OFF) begin
            if (req_seen) begin
                stub_addr_ok = 1'b1;
                req_seen     = 1'b0;
                addr_log.push_back(inst_addr);
                ack_cyc_log.push_back(cyc);
                $display("request addr=%08h cyc=%0d", inst_addr, cyc);
                if (mode == M_SAME) begin
                    stub_data_ok = 1'b1;
                    stub_rdata   = inst_addr ^ XOR_K;
                end else if (mode == M_NORMAL) begin
                    pend  = 2;
                    paddr = inst_addr;
                end
            end else begin
                req_seen = 1'b1;
            end
        end else begin
            req_seen = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (disp_valid) begin
            cap_data_log.push_back(disp_data);
            cap_idx_log.push_back(int'(word_idx));
            cap_cyc_log.push_back(cyc);
            $display("capture idx=%0d data=%08h cyc=%0d", word_idx, disp_data, cyc);
        end
        if (inst_req && !prev_req) rise_cyc_log.push_back(cyc);
        if (done) done_hi++;
        if (done && !prev_done) done_rises++;
        prev_req  = inst_req;
        prev_done = done;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        frc_data_ok = 1'b0;
        mode = M_OFF;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        run = 1'b0;
        frc_data_ok = 1'b0;
        mode = M_OFF;
        repeat (3) tick();
        n_checks++; if (inst_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", inst_req); end
        n_checks++; if (inst_addr !== BASE) begin n_fail++; $display("FAIL reset_addr: got %08h want %08h", inst_addr, BASE); end
        n_checks++; if (disp_data !== 32'h0) begin n_fail++; $display("FAIL reset_disp_data: got %08h want 0", disp_data); end
        n_checks++; if ({disp_valid, done, err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {disp_valid, done, err}); end
        n_checks++; if (word_idx !== 3'd0) begin n_fail++; $display("FAIL reset_word_idx: got %0d want 0", word_idx); end
        n_checks++; if ({inst_wr, inst_size} !== 3'b010) begin n_fail++; $display("FAIL const_wr_size: got %b want 010", {inst_wr, inst_size}); end
        rst = 1'b0;
        repeat (3) tick();
        n_checks++; if (inst_req !== 1'b0) begin n_fail++; $display("FAIL idle_no_run_req: got %b want 0", inst_req); end
    endtask

    task automatic test_basic();
        int a0, c0;
        bit req_seen_after;
        do_reset();
        a0 = addr_log.size();
        c0 = cap_data_log.size();
        mode = M_NORMAL;
        run = 1'b1;
        for (int i = 0; i < 300 && done !== 1'b1; i++) tick();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b want 1", done); end
        n_checks++; if (addr_log.size() - a0 != WC) begin n_fail++; $display("FAIL basic_nreq: got %0d want %0d", addr_log.size() - a0, WC); end
        n_checks++; if (cap_data_log.size() - c0 != WC) begin n_fail++; $display("FAIL basic_ncap: got %0d want %0d", cap_data_log.size() - c0, WC); end
        for (int k = 0; k < WC; k++) begin
            logic [31:0] exp_a;
            exp_a = BASE + 32'(4 * k);
            n_checks++; if (addr_log[a0 + k] !== exp_a) begin n_fail++; $display("FAIL basic_addr%0d: got %08h want %08h", k, addr_log[a0 + k], exp_a); end
            n_checks++; if (cap_data_log[c0 + k] !== (exp_a ^ XOR_K)) begin n_fail++; $display("FAIL basic_data%0d: got %08h want %08h", k, cap_data_log[c0 + k], exp_a ^ XOR_K); end
            n_checks++; if (cap_idx_log[c0 + k] != k) begin n_fail++; $display("FAIL basic_idx%0d: got %0d want %0d", k, cap_idx_log[c0 + k], k); end
        end
`ifndef FETCH_LOOP_EN
        req_seen_after = 1'b0;
        repeat (10) begin
            tick();
            if (inst_req !== 1'b0) req_seen_after = 1'b1;
        end
        n_checks++; if (req_seen_after) begin n_fail++; $display("FAIL basic_req_after_done: got 1 want 0"); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done_sticky: got %b want 1", done); end
`endif
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b want 0", err); end
    endtask

    task automatic test_same_cycle();
        int r0, k0, v0;
        do_reset();
        r0 = rise_cyc_log.size();
        k0 = ack_cyc_log.size();
        v0 = cap_cyc_log.size();
        mode = M_SAME;
        run = 1'b1;
        for (int i = 0; i < 100 && rise_cyc_log.size() < r0 + 2; i++) tick();
        n_checks++; if (rise_cyc_log.size() < r0 + 2) begin n_fail++; $display("FAIL same_second_req: got %0d reqs want 2", rise_cyc_log.size() - r0); end
        n_checks++; if (rise_cyc_log[r0 + 1] - ack_cyc_log[k0] != DW + 1) begin n_fail++; $display("FAIL same_next_req_gap: got %0d want %0d", rise_cyc_log[r0 + 1] - ack_cyc_log[k0], DW + 1); end
        n_checks++; if (cap_cyc_log[v0] - ack_cyc_log[k0] != 1) begin n_fail++; $display("FAIL same_capture_lat: got %0d want 1", cap_cyc_log[v0] - ack_cyc_log[k0]); end
        n_checks++; if (cap_data_log[v0] !== (BASE ^ XOR_K)) begin n_fail++; $display("FAIL same_data: got %08h want %08h", cap_data_log[v0], BASE ^ XOR_K); end
        run = 1'b0;
    endtask

    task automatic test_timeout();
        int k0, c0, ecyc;
        logic [31:0] held;
        do_reset();
        k0 = ack_cyc_log.size();
        c0 = cap_data_log.size();
        mode = M_NODATA;
        run = 1'b1;
        for (int i = 0; i < 100 && err !== 1'b1; i++) tick();
        ecyc = cyc;
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b want 1", err); end
        n_checks++; if (ecyc - ack_cyc_log[k0] != TO + 1) begin n_fail++; $display("FAIL tmo_latency: got %0d want %0d", ecyc - ack_cyc_log[k0], TO + 1); end
        repeat (3) tick();
        n_checks++; if ({inst_req, done, err} !== 3'b001) begin n_fail++; $display("FAIL tmo_done_state: got %b want 001", {inst_req, done, err}); end
        held = disp_data;
        frc_rdata = 32'hDEADBEEF;
        frc_data_ok = 1'b1;
        tick();
        frc_data_ok = 1'b0;
        n_checks++; if (disp_valid !== 1'b0) begin n_fail++; $display("FAIL tmo_late_valid: got %b want 0", disp_valid); end
        tick();
        n_checks++; if (disp_data !== 32'h0) begin n_fail++; $display("FAIL tmo_late_data: got %08h want 0 (held %08h)", disp_data, held); end
        n_checks++; if (cap_data_log.size() != c0) begin n_fail++; $display("FAIL tmo_capture_count: got %0d want 0", cap_data_log.size() - c0); end
    endtask

    task automatic test_run_drop();
        int a0, c0;
        bit req_seen_parked;
        do_reset();
        a0 = addr_log.size();
        c0 = cap_data_log.size();
        mode = M_NORMAL;
        run = 1'b1;
        for (int i = 0; i < 100 && cap_data_log.size() < c0 + 2; i++) tick();
        run = 1'b0;
        n_checks++; if (cap_data_log[c0 + 1] !== ((BASE + 32'd4) ^ XOR_K)) begin n_fail++; $display("FAIL drop_word1_data: got %08h want %08h", cap_data_log[c0 + 1], (BASE + 32'd4) ^ XOR_K); end
        req_seen_parked = 1'b0;
        repeat (20) begin
            tick();
            if (inst_req !== 1'b0) req_seen_parked = 1'b1;
        end
        n_checks++; if (req_seen_parked) begin n_fail++; $display("FAIL drop_req_while_parked: got 1 want 0"); end
        n_checks++; if (addr_log.size() - a0 != 2) begin n_fail++; $display("FAIL drop_nreq: got %0d want 2", addr_log.size() - a0); end
        n_checks++; if (inst_addr !== BASE + 32'd8) begin n_fail++; $display("FAIL drop_kept_addr: got %08h want %08h", inst_addr, BASE + 32'd8); end
        run = 1'b1;
        for (int i = 0; i < 50 && addr_log.size() < a0 + 3; i++) tick();
        n_checks++; if (addr_log[a0 + 2] !== BASE + 32'd8) begin n_fail++; $display("FAIL drop_resume_addr: got %08h want %08h", addr_log[a0 + 2], BASE + 32'd8); end
        run = 1'b0;
    endtask

    task automatic test_reset_mid();
        int r0, c0;
        do_reset();
        r0 = rise_cyc_log.size();
        mode = M_NORMAL;
        run = 1'b1;
        for (int i = 0; i < 100 && rise_cyc_log.size() < r0 + 2; i++) tick();
        n_checks++; if ({inst_req, inst_addr} !== {1'b1, BASE + 32'd4}) begin n_fail++; $display("FAIL rstmid_pre: got req=%b addr=%08h want req=1 addr=%08h", inst_req, inst_addr, BASE + 32'd4); end
        rst = 1'b1;
        run = 1'b0;
        tick();
        n_checks++; if (inst_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_req: got %b want 0", inst_req); end
        n_checks++; if (inst_addr !== BASE) begin n_fail++; $display("FAIL rstmid_addr: got %08h want %08h", inst_addr, BASE); end
        n_checks++; if ({done, err, disp_data} !== {2'b00, 32'h0}) begin n_fail++; $display("FAIL rstmid_state: got done=%b err=%b data=%08h want 0 0 0", done, err, disp_data); end
        mode = M_OFF;
        rst = 1'b0;
        tick();
        c0 = cap_data_log.size();
        frc_rdata = 32'h12345678;
        frc_data_ok = 1'b1;
        tick();
        frc_data_ok = 1'b0;
        n_checks++; if (disp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_stray_valid: got %b want 0", disp_valid); end
        tick();
        n_checks++; if (disp_data !== 32'h0) begin n_fail++; $display("FAIL rstmid_stray_data: got %08h want 0", disp_data); end
        n_checks++; if (cap_data_log.size() != c0) begin n_fail++; $display("FAIL rstmid_capture_count: got %0d want 0", cap_data_log.size() - c0); end
    endtask

`ifdef FETCH_LOOP_EN
    task automatic test_loop();
        int a0, dr0, dh0;
        do_reset();
        a0  = addr_log.size();
        dr0 = done_rises;
        dh0 = done_hi;
        mode = M_NORMAL;
        run = 1'b1;
        for (int i = 0; i < 400 && addr_log.size() < a0 + 9; i++) tick();
        n_checks++; if (addr_log.size() < a0 + 9) begin n_fail++; $display("FAIL loop_nreq: got %0d want 9", addr_log.size() - a0); end
        n_checks++; if (addr_log[a0 + 3] !== BASE + 32'd12) begin n_fail++; $display("FAIL loop_last_addr: got %08h want %08h", addr_log[a0 + 3], BASE + 32'd12); end
        n_checks++; if (addr_log[a0 + 4] !== BASE) begin n_fail++; $display("FAIL loop_wrap1: got %08h want %08h", addr_log[a0 + 4], BASE); end
        n_checks++; if (addr_log[a0 + 8] !== BASE) begin n_fail++; $display("FAIL loop_wrap2: got %08h want %08h", addr_log[a0 + 8], BASE); end
        n_checks++; if (done_rises - dr0 != 2) begin n_fail++; $display("FAIL loop_done_pulses: got %0d want 2", done_rises - dr0); end
        n_checks++; if (done_hi - dh0 != 2) begin n_fail++; $display("FAIL loop_done_width: got %0d cycles want 2", done_hi - dh0); end
        run = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1;
        run = 1'b0;
        frc_data_ok = 1'b0;
        frc_rdata = '0;
        mode = M_OFF;
        test_reset();
        test_basic();
        test_same_cycle();
        test_timeout();
        test_run_drop();
        test_reset_mid();
`ifdef FETCH_LOOP_EN
        test_loop();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch_seq.md
Name: inst_fetch_seq

Overview:
- Sram-like instruction-port master that walks a block of boot-flash words and feeds the segment display.
- Drives inst_req/inst_addr into cpu_axi_interface, which reads through the AXI port of spi_flash_ctrl.
- Captures each returned word, holds it on the display bus for a programmable dwell time, then fetches the next word.
- Replaces the free-running single-address request logic in the flash bring-up harness.

Parameters:
- BASE_ADDR, 32'h1fc00000, first fetch address (word-aligned).
- WORD_COUNT, 16, words per pass (>=1).
- DWELL_CYCLES, 50000000, cycles each captured word is held before the next request (0 = no dwell).
- TIMEOUT_CYCLES, 1000000, maximum WAIT cycles before err is raised.

Ports:
- clk  in  1  CPU clock.
- rst  in  1  synchronous reset, active-high.
- run  in  1  level; starts and continues fetching while high.
- inst_req  out  1  sram-like request.
- inst_wr  out  1  constant 0.
- inst_size  out  2  constant 2'b10.
- inst_addr  out  32  fetch address.
- inst_addr_ok  in  1  request accepted.
- inst_data_ok  in  1  read data valid.
- inst_rdata  in  32  read data.
- disp_data  out  32  last captured word, to SegDisplay.
- disp_valid  out  1  pulse, 1 cycle, on each capture.
- word_idx  out  $clog2(WORD_COUNT+1)  index of word in disp_data.
- done  out  1  pass complete (sticky until reset).
- err  out  1  timeout seen (sticky until reset).

Behaviour:
Reset values:
- rst high at posedge forces state IDLE.
- inst_req=0, inst_addr=BASE_ADDR, disp_data=0, disp_valid=0, word_idx=0, done=0, err=0; all counters 0.
- Reset mid-transaction drops inst_req the same edge. A late inst_data_ok after reset is ignored.

States:
- IDLE: if run, go to REQ next cycle.
- REQ: inst_req=1, inst_addr stable.
  - On a cycle with inst_addr_ok=1: deassert inst_req next cycle and go to WAIT.
  - If inst_data_ok=1 in the same cycle: capture and go to DWELL directly.
- WAIT: inst_req=0; the timeout counter increments each cycle.
  - On inst_data_ok: disp_data<=inst_rdata, disp_valid=1 for one cycle, word_idx<=current index, go to DWELL.
  - If the counter reaches TIMEOUT_CYCLES: err<=1, go to DONE. A later data_ok is ignored.
- DWELL: counter counts DWELL_CYCLES cycles; with DWELL_CYCLES=0 leave after 1 cycle. On expiry:
  - If index==WORD_COUNT-1: done<=1, go to DONE.
  - Otherwise index+1, inst_addr+4 (32-bit wrap, no carry check), go to REQ if run, else IDLE. The address is kept for resume.
- DONE: inst_req=0, outputs hold.

Handshake and boundary rules:
- Only one outstanding request.
- inst_addr never changes while inst_req=1.
- inst_data_ok outside WAIT/REQ is ignored.
- run deasserted in REQ does not withdraw the request; the word completes first.
- run low in WAIT/DWELL: the current word completes, then the block parks in IDLE.
- Counters saturate; no overflow.

Optional Feature:
- Macro: FETCH_LOOP_EN.
- Defined: at the last word, DWELL expiry wraps index to 0 and inst_addr to BASE_ADDR, and goes to REQ. done pulses for 1 cycle per completed pass instead of being sticky. err still goes to DONE.
- Undefined: single pass; done is sticky as above.

Decomposition:
- Package fetch_seq_pkg:
  - State enum (IDLE, REQ, WAIT, DWELL, DONE).
  - Constants: INST_SIZE_WORD = 2'b10, ADDR_STEP = 4.
- Sub-module sat_counter (parameter MAX; load/enable/hit), instantiated for both the dwell counter and the timeout counter.

Test Plan (WORD_COUNT=4, DWELL_CYCLES=3, TIMEOUT_CYCLES=20, stub slave with addr_ok 1 cycle after req, data_ok 2 cycles later, rdata=addr^32'hA5A5A5A5):
- run=1 from reset -> addresses 1fc00000, 04, 08, 0c requested in order. 4 disp_valid pulses, disp_data=1fc00000^A5A5A5A5 first. done=1 after the 4th dwell; inst_req stays 0.
- Stub asserts addr_ok and data_ok in the same cycle -> capture in that cycle, no WAIT state, next request exactly DWELL+1 cycles later.
- Stub never returns data_ok -> err=1 after 20 WAIT cycles, state DONE. A later data_ok leaves disp_data unchanged.
- run dropped during DWELL of word 1 -> no new req. Raising run again resumes at 1fc00008.
- rst pulsed while inst_req=1 -> inst_req=0 next cycle, inst_addr=1fc00000, done=err=0. A stray data_ok is ignored.
- FETCH_LOOP_EN defined -> after word 3, next req addr=1fc00000; done pulses 1 cycle per pass over 2 passes.
